id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register for the RISC-V pipelined processing unit, sitting directly downstream of the instruction control unit. Each cycle it captures the decoded control word, operands, PC and immediate into EX-stage registers. It also detects load-use hazards, requesting an upstream stall and inserting a bubble, and honours a branch/jump flush from EX and a hold from later stages.

## Interface
- No parameters; all widths fixed (RV32I).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ID_load_Instr, ID_RF_enable, RAM_Enable, RAM_RW, RAM_SE, JALR_Instr, JAL_Instr, AUIPC_Instr  in  1 each  decoded control bits
- ID_shift_imm  in  3  immediate format: 000 none, 001 I, 010 S, 011 U, others none
- ID_ALU_op  in  4  ALU operation
- RAM_Size  in  2  00 byte, 01 half, 10 word
- Comb_OpFunct  in  10  {funct3, opcode}
- ID_Instruction  in  32  raw instruction word in ID
- ID_PC  in  32  PC of the ID instruction
- ID_PA, ID_PB  in  32 each  rs1/rs2 operand values
- EX_flush  in  1  taken branch/jump resolved in EX; squash the ID instruction
- EX_hold  in  1  later stage stalled; freeze this register
- EX_* outputs  out  same widths  registered copies of every control input above (EX_load_Instr, EX_RF_enable, EX_RAM_Enable, EX_RAM_RW, EX_RAM_SE, EX_JALR_Instr, EX_JAL_Instr, EX_AUIPC_Instr, EX_shift_imm, EX_ALU_op, EX_RAM_Size, EX_Comb_OpFunct)
- EX_PC, EX_PA, EX_PB, EX_imm  out  32 each
- EX_rd  out  5  destination register, Instruction[11:7]
- EX_valid  out  1  1 = real instruction, 0 = bubble
- ID_stall  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt  out  16  saturating count of inserted bubbles

## Operation
- Immediate generation from ID_Instruction per ID_shift_imm:
  - I: sign-extend [31:20]
  - S: sign-extend {[31:25],[11:7]}
  - U: {[31:12],12'b0}
  - otherwise 0
- rs1 = [19:15], rs2 = [24:20].
- rs1 use: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111 and 0000000.
- rs2 use: opcodes 0110011, 0100011, 1100011 only.
- Load-use hazard: EX_valid & EX_load_Instr & EX_RF_enable & (EX_rd != 0) & ((rs1 use & rs1==EX_rd) | (rs2 use & rs2==EX_rd)).
- Per-edge update, in priority order:
  1. reset: all outputs 0.
  2. EX_hold: all EX_* held unchanged.
  3. EX_flush: bubble.
  4. hazard: bubble.
  5. otherwise: capture inputs, EX_valid=1.
- Bubble: all EX_* control bits and fields 0, EX_PC/PA/PB/imm/rd 0, EX_valid 0 (equivalent to decoder NOP).
- ID_stall = EX_hold | (hazard & ~EX_flush). Flush squashes the ID instruction, so no stall request accompanies it.
- bubble_cnt increments by 1 on each edge that loads a bubble due to flush or hazard. Hold and reset do not increment. Saturates at 0xFFFF.
- The EX_flush source keeps EX_flush asserted for as long as EX_hold is high; a flush is not lost under hold.

## Timing
- Latency: 1 cycle, ID inputs to EX outputs.
- Reset values: every output 0. ID_stall follows its equation, which is 0 after reset since EX_valid=0 and assuming EX_hold=0.
- Load-use gives exactly one bubble. The next cycle EX_valid=0, so the hazard clears and the held ID instruction is captured.
- Reset asserted mid-stall or mid-hold clears everything on that edge. No hazard state survives.
- Simultaneous EX_flush and hazard: one bubble, one bubble_cnt increment, ID_stall=0.
- Simultaneous EX_hold and EX_flush: hold wins; contents unchanged, ID_stall=1.
- Hazard where the EX load has EX_rd=0: no stall.

## Test plan
- Reset, then capture addi x1,x0,-1 (0xFFF00093, shift_imm 001, ALU_op 0010): next cycle EX_imm=0xFFFFFFFF, EX_rd=1, EX_ALU_op=0010, EX_valid=1.
- lw x5,0(x1) (0x0000A283) followed by add x6,x5,x2 (0x00228333): ID_stall=1 for one cycle, bubble loaded (EX_valid=0), bubble_cnt=1, then add captured with EX_rd=6.
- lw x5 in EX, then sw x5,8(x2) (0x00512423) in ID: rs2 hazard, one bubble. Captured store has EX_imm=8, EX_RAM_RW=1, EX_RAM_Size=10, EX_RF_enable=0.
- lui x5,0x12345 (0x123452B7) after lw x5: no stall, since LUI uses no rs1. EX_imm=0x12345000.
- EX_flush with valid ADDI in ID: bubble loaded, ID_stall=0. Then EX_hold and EX_flush together for 3 cycles: EX_* frozen, ID_stall=1, bubble_cnt unchanged.
- Force 65536 flush cycles: bubble_cnt stays 0xFFFF. Assert reset mid-hold: all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded instruction into EX, inserts
// bubbles on flush or load-use hazard, and freezes under a downstream hold.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_load_Instr,
  input  logic        ID_RF_enable,
  input  logic        RAM_Enable,
  input  logic        RAM_RW,
  input  logic        RAM_SE,
  input  logic        JALR_Instr,
  input  logic        JAL_Instr,
  input  logic        AUIPC_Instr,
  input  logic [2:0]  ID_shift_imm,
  input  logic [3:0]  ID_ALU_op,
  input  logic [1:0]  RAM_Size,
  input  logic [9:0]  Comb_OpFunct,
  input  logic [31:0] ID_Instruction,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_PA,
  input  logic [31:0] ID_PB,
  input  logic        EX_flush,
  input  logic        EX_hold,
  output logic        EX_load_Instr,
  output logic        EX_RF_enable,
  output logic        EX_RAM_Enable,
  output logic        EX_RAM_RW,
  output logic        EX_RAM_SE,
  output logic        EX_JALR_Instr,
  output logic        EX_JAL_Instr,
  output logic        EX_AUIPC_Instr,
  output logic [2:0]  EX_shift_imm,
  output logic [3:0]  EX_ALU_op,
  output logic [1:0]  EX_RAM_Size,
  output logic [9:0]  EX_Comb_OpFunct,
  output logic [31:0] EX_PC,
  output logic [31:0] EX_PA,
  output logic [31:0] EX_PB,
  output logic [31:0] EX_imm,
  output logic [4:0]  EX_rd,
  output logic        EX_valid,
  output logic        ID_stall,
  output logic [15:0] bubble_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic             load;
    logic             rf_en;
    logic             ram_en;
    logic             ram_rw;
    logic             ram_se;
    logic             jalr;
    logic             jal;
    logic             auipc;
    logic [2:0]       shift_imm;
    logic [3:0]       alu_op;
    logic [1:0]       ram_size;
    logic [9:0]       op_funct;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pa;
    logic [XLEN-1:0]  pb;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rd;
    logic             valid;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  imm;
  logic [6:0]       opcode;
  logic [4:0]       rs1, rs2;
  logic             rs1_use, rs2_use, hazard;

  assign opcode = ID_Instruction[6:0];
  assign rs1    = ID_Instruction[19:15];
  assign rs2    = ID_Instruction[24:20];

  // Immediate generation by format
  always_comb begin
    imm = '0;
    case (ID_shift_imm)
      3'b001:  imm = {{20{ID_Instruction[31]}}, ID_Instruction[31:20]};
      3'b010:  imm = {{20{ID_Instruction[31]}}, ID_Instruction[31:25], ID_Instruction[11:7]};
      3'b011:  imm = {ID_Instruction[31:12], 12'b0};
      default: imm = '0;
    endcase
  end

  // Load-use hazard against the instruction currently in EX
  assign rs1_use = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000});
  assign rs2_use = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign hazard  = ex_q.valid & ex_q.load & ex_q.rf_en & (ex_q.rd != 5'd0) &
                   ((rs1_use & (rs1 == ex_q.rd)) | (rs2_use & (rs2 == ex_q.rd)));
  assign ID_stall = EX_hold | (hazard & ~EX_flush);

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (EX_hold) begin
      ex_d = ex_q;
    end else if (EX_flush || hazard) begin
      ex_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.load      = ID_load_Instr;
      ex_d.rf_en     = ID_RF_enable;
      ex_d.ram_en    = RAM_Enable;
      ex_d.ram_rw    = RAM_RW;
      ex_d.ram_se    = RAM_SE;
      ex_d.jalr      = JALR_Instr;
      ex_d.jal       = JAL_Instr;
      ex_d.auipc     = AUIPC_Instr;
      ex_d.shift_imm = ID_shift_imm;
      ex_d.alu_op    = ID_ALU_op;
      ex_d.ram_size  = RAM_Size;
      ex_d.op_funct  = Comb_OpFunct;
      ex_d.pc        = ID_PC;
      ex_d.pa        = ID_PA;
      ex_d.pb        = ID_PB;
      ex_d.imm       = imm;
      ex_d.rd        = ID_Instruction[11:7];
      ex_d.valid     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign EX_load_Instr   = ex_q.load;
  assign EX_RF_enable    = ex_q.rf_en;
  assign EX_RAM_Enable   = ex_q.ram_en;
  assign EX_RAM_RW       = ex_q.ram_rw;
  assign EX_RAM_SE       = ex_q.ram_se;
  assign EX_JALR_Instr   = ex_q.jalr;
  assign EX_JAL_Instr    = ex_q.jal;
  assign EX_AUIPC_Instr  = ex_q.auipc;
  assign EX_shift_imm    = ex_q.shift_imm;
  assign EX_ALU_op       = ex_q.alu_op;
  assign EX_RAM_Size     = ex_q.ram_size;
  assign EX_Comb_OpFunct = ex_q.op_funct;
  assign EX_PC           = ex_q.pc;
  assign EX_PA           = ex_q.pa;
  assign EX_PB           = ex_q.pb;
  assign EX_imm          = ex_q.imm;
  assign EX_rd           = ex_q.rd;
  assign EX_valid        = ex_q.valid;
  assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued when each
// ID instruction is driven and checked after the capturing edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_load_Instr, ID_RF_enable, RAM_Enable, RAM_RW, RAM_SE;
  logic        JALR_Instr, JAL_Instr, AUIPC_Instr;
  logic [2:0]  ID_shift_imm;
  logic [3:0]  ID_ALU_op;
  logic [1:0]  RAM_Size;
  logic [9:0]  Comb_OpFunct;
  logic [31:0] ID_Instruction, ID_PC, ID_PA, ID_PB;
  logic        EX_flush, EX_hold;
  logic        EX_load_Instr, EX_RF_enable, EX_RAM_Enable, EX_RAM_RW, EX_RAM_SE;
  logic        EX_JALR_Instr, EX_JAL_Instr, EX_AUIPC_Instr;
  logic [2:0]  EX_shift_imm;
  logic [3:0]  EX_ALU_op;
  logic [1:0]  EX_RAM_Size;
  logic [9:0]  EX_Comb_OpFunct;
  logic [31:0] EX_PC, EX_PA, EX_PB, EX_imm;
  logic [4:0]  EX_rd;
  logic        EX_valid, ID_stall;
  logic [15:0] bubble_cnt;

  typedef struct packed {
    logic        load, rf, ram_en, ram_rw, ram_se, jalr, jal, auipc;
    logic [2:0]  sh;
    logic [3:0]  alu;
    logic [1:0]  size;
    logic [9:0]  of;
    logic [31:0] pc, pa, pb, imm;
    logic [4:0]  rd;
    logic        valid;
    logic [15:0] cnt;
  } obs_t;

  localparam int CAP = 0, BUB = 1, HOLD = 2, RST = 3;

  obs_t        sb[$];
  obs_t        last_e;
  logic [15:0] exp_cnt;
  int          nvec = 0;
  int          nerr = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .ID_load_Instr(ID_load_Instr), .ID_RF_enable(ID_RF_enable),
    .RAM_Enable(RAM_Enable), .RAM_RW(RAM_RW), .RAM_SE(RAM_SE),
    .JALR_Instr(JALR_Instr), .JAL_Instr(JAL_Instr), .AUIPC_Instr(AUIPC_Instr),
    .ID_shift_imm(ID_shift_imm), .ID_ALU_op(ID_ALU_op), .RAM_Size(RAM_Size),
    .Comb_OpFunct(Comb_OpFunct), .ID_Instruction(ID_Instruction),
    .ID_PC(ID_PC), .ID_PA(ID_PA), .ID_PB(ID_PB),
    .EX_flush(EX_flush), .EX_hold(EX_hold),
    .EX_load_Instr(EX_load_Instr), .EX_RF_enable(EX_RF_enable),
    .EX_RAM_Enable(EX_RAM_Enable), .EX_RAM_RW(EX_RAM_RW), .EX_RAM_SE(EX_RAM_SE),
    .EX_JALR_Instr(EX_JALR_Instr), .EX_JAL_Instr(EX_JAL_Instr),
    .EX_AUIPC_Instr(EX_AUIPC_Instr), .EX_shift_imm(EX_shift_imm),
    .EX_ALU_op(EX_ALU_op), .EX_RAM_Size(EX_RAM_Size),
    .EX_Comb_OpFunct(EX_Comb_OpFunct), .EX_PC(EX_PC), .EX_PA(EX_PA),
    .EX_PB(EX_PB), .EX_imm(EX_imm), .EX_rd(EX_rd), .EX_valid(EX_valid),
    .ID_stall(ID_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.load = EX_load_Instr;  o.rf = EX_RF_enable;   o.ram_en = EX_RAM_Enable;
    o.ram_rw = EX_RAM_RW;    o.ram_se = EX_RAM_SE;  o.jalr = EX_JALR_Instr;
    o.jal = EX_JAL_Instr;    o.auipc = EX_AUIPC_Instr;
    o.sh = EX_shift_imm;     o.alu = EX_ALU_op;     o.size = EX_RAM_Size;
    o.of = EX_Comb_OpFunct;  o.pc = EX_PC;          o.pa = EX_PA;
    o.pb = EX_PB;            o.imm = EX_imm;        o.rd = EX_rd;
    o.valid = EX_valid;      o.cnt = bubble_cnt;
    return o;
  endfunction

  task automatic set_id(input logic [31:0] instr, input logic [2:0] sh,
                        input logic [3:0] alu, input logic load, input logic rf,
                        input logic ren, input logic rw, input logic [1:0] size,
                        input logic [31:0] pc, input logic [31:0] pa,
                        input logic [31:0] pb);
    ID_Instruction = instr; ID_shift_imm = sh; ID_ALU_op = alu;
    ID_load_Instr = load; ID_RF_enable = rf; RAM_Enable = ren; RAM_RW = rw;
    RAM_Size = size; RAM_SE = load; JALR_Instr = 1'b0; JAL_Instr = 1'b0;
    AUIPC_Instr = 1'b0; Comb_OpFunct = {instr[14:12], instr[6:0]};
    ID_PC = pc; ID_PA = pa; ID_PB = pb;
  endtask

  // Check the stall request, queue the expected EX contents, clock, compare
  task automatic step(input string tag, input bit chk_stall, input logic exp_stall,
                      input int kind, input logic [31:0] exp_imm);
    obs_t e, o;
    #1;
    if (chk_stall) begin
      nvec++;
      assert (ID_stall === exp_stall)
      else begin
        nerr++;
        $error("FAIL %s_stall: observed %b expected %b", tag, ID_stall, exp_stall);
      end
    end
    e = '0;
    case (kind)
      CAP: begin
        e.load = ID_load_Instr; e.rf = ID_RF_enable; e.ram_en = RAM_Enable;
        e.ram_rw = RAM_RW; e.ram_se = RAM_SE; e.jalr = JALR_Instr;
        e.jal = JAL_Instr; e.auipc = AUIPC_Instr; e.sh = ID_shift_imm;
        e.alu = ID_ALU_op; e.size = RAM_Size; e.of = Comb_OpFunct;
        e.pc = ID_PC; e.pa = ID_PA; e.pb = ID_PB; e.imm = exp_imm;
        e.rd = ID_Instruction[11:7]; e.valid = 1'b1; e.cnt = exp_cnt;
      end
      BUB: begin
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        e.cnt = exp_cnt;
      end
      HOLD: e = last_e;
      default: begin
        exp_cnt = 16'd0;
        e = '0;
      end
    endcase
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sample();
    nvec++;
    if (sb.size() == 0) begin
      nerr++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb.pop_front();
      assert (o === e)
      else begin
        nerr++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
      last_e = e;
    end
    @(negedge clk);
  endtask

  initial begin
    exp_cnt = 16'd0;
    last_e  = '0;
    reset = 1'b1; EX_flush = 1'b0; EX_hold = 1'b0;
    set_id(32'h0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    step("reset", 1'b0, 1'b0, RST, 32'h0);
    reset = 1'b0;

    // addi x1,x0,-1
    set_id(32'hFFF00093, 3'b001, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h100, 32'h0, 32'h0);
    step("addi", 1'b1, 1'b0, CAP, 32'hFFFFFFFF);
    // lw x5,0(x1) then add x6,x5,x2: one bubble, then capture
    set_id(32'h0000A283, 3'b001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h104, 32'hFFFFFFFF, 32'h0);
    step("lw_x5", 1'b1, 1'b0, CAP, 32'h0);
    set_id(32'h00228333, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h108, 32'h55, 32'hAA);
    step("add_haz", 1'b1, 1'b1, BUB, 32'h0);
    step("add_cap", 1'b1, 1'b0, CAP, 32'h0);
    // lw x5 then sw x5,8(x2): rs2 hazard
    set_id(32'h0000A283, 3'b001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h10C, 32'h1000, 32'h0);
    step("lw_x5b", 1'b1, 1'b0, CAP, 32'h0);
    set_id(32'h00512423, 3'b010, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 32'h110, 32'h2000, 32'h77);
    step("sw_haz", 1'b1, 1'b1, BUB, 32'h0);
    step("sw_cap", 1'b1, 1'b0, CAP, 32'h8);
    // lw x8 then lui x5,0x12345 whose rs1 field is 8: no rs1 use, no stall
    set_id(32'h0000A403, 3'b001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h114, 32'h3000, 32'h0);
    step("lw_x8", 1'b1, 1'b0, CAP, 32'h0);
    set_id(32'h123452B7, 3'b011, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h118, 32'h0, 32'h0);
    step("lui", 1'b1, 1'b0, CAP, 32'h12345000);
    // lw x0 then add x6,x0,x0: rd 0 never stalls
    set_id(32'h0000A003, 3'b001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h11C, 32'h0, 32'h0);
    step("lw_x0", 1'b1, 1'b0, CAP, 32'h0);
    set_id(32'h00000333, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h120, 32'h0, 32'h0);
    step("add_x0", 1'b1, 1'b0, CAP, 32'h0);
    // flush with a valid addi in ID
    set_id(32'hFFF00093, 3'b001, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h124, 32'h0, 32'h0);
    EX_flush = 1'b1;
    step("flush", 1'b1, 1'b0, BUB, 32'h0);
    EX_flush = 1'b0;
    // flush coinciding with a load-use hazard: one bubble, no stall
    set_id(32'h0000A283, 3'b001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 32'h128, 32'h4, 32'h0);
    step("lw_x5c", 1'b1, 1'b0, CAP, 32'h0);
    set_id(32'h00228333, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h12C, 32'h9, 32'h3);
    EX_flush = 1'b1;
    step("flush_haz", 1'b1, 1'b0, BUB, 32'h0);
    EX_flush = 1'b0;
    // hold with flush for 3 cycles freezes a captured addi
    set_id(32'hFFF00093, 3'b001, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h130, 32'h0, 32'h0);
    step("addi_pre_hold", 1'b1, 1'b0, CAP, 32'hFFFFFFFF);
    EX_hold = 1'b1; EX_flush = 1'b1;
    for (int i = 0; i < 3; i++) step("hold_flush", 1'b1, 1'b1, HOLD, 32'h0);
    EX_hold = 1'b0;
    step("flush_after_hold", 1'b1, 1'b0, BUB, 32'h0);
    // saturation: 65536 flushed edges
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    @(negedge clk);
    step("sat", 1'b1, 1'b0, BUB, 32'h0);
    EX_flush = 1'b0;
    // reset asserted mid-hold clears everything
    step("addi_pre_rst", 1'b1, 1'b0, CAP, 32'hFFFFFFFF);
    EX_hold = 1'b1;
    step("hold", 1'b1, 1'b1, HOLD, 32'h0);
    reset = 1'b1;
    step("reset_hold", 1'b0, 1'b0, RST, 32'h0);
    reset = 1'b0; EX_hold = 1'b0;
    step("addi_post_rst", 1'b1, 1'b0, CAP, 32'hFFFFFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
